// File: rtl/fft_load_if.sv
// fft_load_if: sample stream, FFT handshake and bank-write bus of the FFT input loader
interface fft_load_if #(parameter int DATA_W = 16);
  logic              iVALID;
  logic              oREADY;
  logic [DATA_W-1:0] iDATA_RE;
  logic [DATA_W-1:0] iDATA_IM;
  logic              iFFT_RDY;
  logic              oSTART;
  logic [3:0]        oWE;
  logic [8:0]        oADDR_WR;
  logic [DATA_W-1:0] oDATA_RE;
  logic [DATA_W-1:0] oDATA_IM;
  logic              oBUSY;
  logic              iCLR_OVF;
  logic [7:0]        oOVF_CNT;
  modport master (
    output iVALID, iDATA_RE, iDATA_IM, iFFT_RDY, iCLR_OVF,
    input  oREADY, oSTART, oWE, oADDR_WR, oDATA_RE, oDATA_IM, oBUSY, oOVF_CNT
  );
  modport slave (
    input  iVALID, iDATA_RE, iDATA_IM, iFFT_RDY, iCLR_OVF,
    output oREADY, oSTART, oWE, oADDR_WR, oDATA_RE, oDATA_IM, oBUSY, oOVF_CNT
  );
endinterface

// File: rtl/fft_load.sv
// fft_load: writes a 2048-sample frame into four 512-word banks, then kicks the FFT and waits for it.
// Optional dropped-valid counter on oOVF_CNT when FFT_LOAD_OVF_EN is defined.
module fft_load #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 11
) (
  input logic       iCLK,
  input logic       iRESET,
  fft_load_if.slave lb
);
  typedef enum logic [1:0] {LOAD, FULL, KICK, BUSY} state_t;
  state_t            state_q, state_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic              seen_low_q, seen_low_d;
  logic              ready_q, busy_q, start_q;
  logic [3:0]        we_q, we_d;
  logic [N_LOG2-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] re_q, re_d, im_q, im_d;
  logic              acc;
  always_comb begin
    acc        = lb.iVALID & ready_q;
    state_d    = (state_q == LOAD) ? ((acc && &cnt_q) ? FULL : LOAD) :
                 (state_q == FULL) ? (lb.iFFT_RDY ? KICK : FULL) :
                 (state_q == KICK) ? BUSY :
                 ((lb.iFFT_RDY && seen_low_q) ? LOAD : BUSY);
    cnt_d      = acc ? cnt_q + 1'b1 : cnt_q;
    // seen_low proves the FFT actually went busy before we trust its ready flag again
    seen_low_d = (state_q == KICK) ? 1'b0 : (state_q == BUSY && !lb.iFFT_RDY) ? 1'b1 : seen_low_q;
    we_d       = acc ? 4'b0001 << cnt_q[N_LOG2-1 -: 2] : 4'b0000;
    addr_d     = acc ? cnt_q[N_LOG2-3:0] : addr_q;
    re_d       = acc ? lb.iDATA_RE : re_q;
    im_d       = acc ? lb.iDATA_IM : im_q;
  end
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      we_q       <= 4'b0000;
      addr_q     <= '0;
      re_q       <= '0;
      im_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      ready_q    <= state_d == LOAD;
      busy_q     <= state_d != LOAD;
      start_q    <= state_d == KICK;
      we_q       <= we_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      im_q       <= im_d;
    end
  end
  assign lb.oREADY   = ready_q;
  assign lb.oBUSY    = busy_q;
  assign lb.oSTART   = start_q;
  assign lb.oWE      = we_q;
  assign lb.oADDR_WR = addr_q;
  assign lb.oDATA_RE = re_q;
  assign lb.oDATA_IM = im_q;
`ifdef FFT_LOAD_OVF_EN
  logic [7:0] ovf_q, ovf_d;
  always_comb ovf_d = lb.iCLR_OVF ? 8'd0 : (lb.iVALID && !ready_q && !(&ovf_q)) ? ovf_q + 8'd1 : ovf_q;
  always_ff @(posedge iCLK) ovf_q <= iRESET ? 8'd0 : ovf_d;
  assign lb.oOVF_CNT = ovf_q;
`else
  logic unused_clr;
  assign unused_clr  = lb.iCLR_OVF;
  assign lb.oOVF_CNT = 8'd0;
`endif
endmodule

// File: tb/tb_fft_load.sv
// tb_fft_load: scoreboard bench for fft_load (bank map, start timing, FFT handshake, reset, overflow counter)
module tb_fft_load;
  logic clk, rst;
  fft_load_if #(.DATA_W(16)) bus ();
  fft_load #(.DATA_W(16), .N_LOG2(11)) dut (.iCLK(clk), .iRESET(rst), .lb(bus));
  typedef struct {int n; logic [15:0] re; logic [15:0] im;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [10:0] nn;
  int total = 0, bad = 0, mcnt = 0, start_cnt = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int n);
    int t = 0;
    bus.iVALID   = 1'b1;
    bus.iDATA_RE = 16'(n);
    bus.iDATA_IM = 16'(-n);
    while (!bus.oREADY && t < 5000) begin
      step();
      t++;
    end
    if (t == 5000) chk("ready_timeout", 0, 1);
    step();
    bus.iVALID = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.oWE != 4'b0000) begin
      if (q.size() == 0) chk("spurious_we", {28'b0, bus.oWE}, 0);
      else begin
        e  = q.pop_front();
        nn = e.n[10:0];
        chk("we", {28'b0, bus.oWE}, 4'b0001 << nn[10:9]);
        chk("addr", {23'b0, bus.oADDR_WR}, {23'b0, nn[8:0]});
        chk("re", {16'b0, bus.oDATA_RE}, {16'b0, e.re});
        chk("im", {16'b0, bus.oDATA_IM}, {16'b0, e.im});
        if (e.n == 0)    chk("map_n0", {19'b0, bus.oWE, bus.oADDR_WR}, {19'b0, 4'b0001, 9'd0});
        if (e.n == 512)  chk("map_n512", {19'b0, bus.oWE, bus.oADDR_WR}, {19'b0, 4'b0010, 9'd0});
        if (e.n == 2047) chk("map_n2047", {19'b0, bus.oWE, bus.oADDR_WR}, {19'b0, 4'b1000, 9'd511});
      end
    end
    if (bus.oSTART) begin
      start_cnt++;
      chk("start_rdy", {31'b0, bus.iFFT_RDY}, 1);
    end
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else if (bus.iVALID && bus.oREADY) begin
      q.push_back('{mcnt, 16'(mcnt), 16'(-mcnt)});
      mcnt = (mcnt + 1) % 2048;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    bus.iVALID = 1'b0;
    bus.iDATA_RE = '0;
    bus.iDATA_IM = '0;
    bus.iFFT_RDY = 1'b1;
    bus.iCLR_OVF = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", {31'b0, bus.oREADY}, 1);
    chk("rst_busy", {31'b0, bus.oBUSY}, 0);
    chk("rst_we", {28'b0, bus.oWE}, 0);
    chk("rst_addr", {23'b0, bus.oADDR_WR}, 0);
    chk("rst_start", {31'b0, bus.oSTART}, 0);
    chk("rst_ovf", {24'b0, bus.oOVF_CNT}, 0);
    chk("rst_data", {bus.oDATA_RE, bus.oDATA_IM}, 0);
    for (int n = 0; n < 2048; n++) send(n);
    chk("f1_full_ready", {31'b0, bus.oREADY}, 0);
    chk("f1_full_start", {31'b0, bus.oSTART}, 0);
    chk("f1_full_busy", {31'b0, bus.oBUSY}, 1);
    step();
    chk("f1_start_t2", {31'b0, bus.oSTART}, 1);
    step();
    chk("f1_start_width", {31'b0, bus.oSTART}, 0);
    chk("f1_start_cnt", start_cnt, 1);
    bus.iVALID = 1'b1;
    repeat (300) step();
    chk("busy_ready", {31'b0, bus.oREADY}, 0);
`ifdef FFT_LOAD_OVF_EN
    chk("ovf_sat", {24'b0, bus.oOVF_CNT}, 255);
    bus.iCLR_OVF = 1'b1;
    step();
    bus.iCLR_OVF = 1'b0;
    chk("ovf_clr", {24'b0, bus.oOVF_CNT}, 0);
`else
    chk("ovf_off", {24'b0, bus.oOVF_CNT}, 0);
    bus.iCLR_OVF = 1'b1;
    step();
    bus.iCLR_OVF = 1'b0;
`endif
    bus.iVALID = 1'b0;
    bus.iFFT_RDY = 1'b0;
    repeat (520) step();
    chk("fft_run_ready", {31'b0, bus.oREADY}, 0);
    bus.iFFT_RDY = 1'b1;
    chk("rise_ready_0", {31'b0, bus.oREADY}, 0);
    step();
    chk("rise_ready_1", {31'b0, bus.oREADY}, 1);
    chk("rise_busy", {31'b0, bus.oBUSY}, 0);
    bus.iFFT_RDY = 1'b0;
    for (int n = 0; n < 2048; n++) begin
      send(n);
      if (n != 2047) repeat (3) step();
    end
    chk("f2_no_early_start", start_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      chk("full_hold_ready", {31'b0, bus.oREADY}, 0);
      chk("full_hold_start", {31'b0, bus.oSTART}, 0);
      step();
    end
    bus.iFFT_RDY = 1'b1;
    chk("f2_pre_start", {31'b0, bus.oSTART}, 0);
    step();
    chk("f2_start", {31'b0, bus.oSTART}, 1);
    step();
    chk("f2_start_width", {31'b0, bus.oSTART}, 0);
    chk("f2_start_cnt", start_cnt, 2);
    bus.iFFT_RDY = 1'b0;
    step();
    bus.iFFT_RDY = 1'b1;
    step();
    chk("f2_release", {31'b0, bus.oREADY}, 1);
    for (int n = 0; n < 700; n++) send(n);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_we", {28'b0, bus.oWE}, 0);
    chk("mid_rst_ready", {31'b0, bus.oREADY}, 1);
    chk("mid_rst_busy", {31'b0, bus.oBUSY}, 0);
    chk("mid_rst_addr", {23'b0, bus.oADDR_WR}, 0);
    send(0);
    step();
    step();
    chk("sb_empty", q.size(), 0);
    chk("final_start_cnt", start_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
